vector_wb_arbiter: RTL and testbench
====================================

Name: vector_wb_arbiter

Overview:
- Shares the single vector-register-file write port between two producers: the VALU result path (ALU) and the scratchpad load return path (SP).
- Each producer gets a one-entry holding register and a valid/ready handshake.
- A round-robin arbiter with same-destination ordering selects one entry per cycle and drives the registered write-back port (wen, vd, vdata, vmask) consumed by the vector register file.

Parameters:
- NUM_ELEMENTS, vector_pkg value, lanes per vector; sets mask width.
- VD_W, $bits(vsel_t), destination register select width.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU result accepted this cycle when valid is also high
- alu_vd  input  VD_W  ALU destination register
- alu_data  input  vreg_t  ALU result vector
- alu_mask  input  NUM_ELEMENTS  ALU lane write mask
- sp_valid  input  1  load data offered
- sp_ready  output  1  load data accepted this cycle when valid is also high
- sp_vd  input  VD_W  load destination register
- sp_data  input  vreg_t  load vector
- sp_mask  input  NUM_ELEMENTS  load lane write mask
- wen  output  1  register file write strobe
- wb_vd  output  VD_W  write destination
- wb_data  output  vreg_t  write data
- wb_mask  output  NUM_ELEMENTS  lane write enables
- busy  output  1  any holding register occupied
- conflict_cnt  output  32  cycles where both sources held data (VWB_PERF_CNT_EN only)

Behaviour:
- Reset (nRST low, asynchronous):
  - Holding registers are invalid.
  - wen=0; wb_vd, wb_data, wb_mask = 0.
  - last_grant = SP, so ALU wins the first contention.
  - Age bit = 0; conflict_cnt = 0.
  - Entries in flight are dropped.
- Handshake:
  - x_ready = !hold_x_valid || grant_x (combinational).
  - A transfer occurs when x_valid && x_ready at a rising edge.
  - Inputs are sampled only on a transfer.
  - Data is held stable internally; producers may drop valid without penalty.
- Arbitration, combinational over the holding registers each cycle:
  - Only one holds data: grant it.
  - Both hold data with different vd: grant the source that is not last_grant.
  - Both hold data with equal vd: grant the older entry (age bit); if both were captured on the same edge, grant ALU.
  - last_grant updates only on a grant.
- Output stage:
  - On a grant, wen<=1 and the wb_* registers load from the granted entry.
  - Otherwise wen<=0 and wb_* hold their previous values.
- Latency: transfer at edge N, holding register valid in cycle N+1, wen high in cycle N+2.
- Throughput:
  - One write per cycle in total.
  - A lone source streams at one transfer per cycle (its ready stays 1).
  - Under contention each source alternates, and its ready drops on the cycle it loses.
- Simultaneous capture and grant of the same source:
  - The new entry replaces the granted one on that edge; no bubble.
- An all-zero mask is still written (wen=1); suppressing it is the register file's decision.
- busy = hold_alu_valid || hold_sp_valid.

Optional Feature:
- Macro: VWB_PERF_CNT_EN.
- Defined: conflict_cnt increments each cycle both holding registers are valid. It saturates at 0xFFFFFFFF and is cleared by reset.
- Undefined: the conflict_cnt port and counter are absent; all other behaviour is identical.

Decomposition:
- vector_pkg gains:
  - wb_src_t enum {WB_ALU, WB_SP}
  - wb_req_t packed struct {vsel_t vd; vreg_t data; logic [NUM_ELEMENTS-1:0] mask}
- Sub-module vector_wb_hold: one-entry holding register with valid/ready, capture and release, instantiated once per source.
- Arbiter, age tracking and output register live in the top module.

Test Plan:
- ALU alone: alu_valid=1, vd=3, data=0x1234 replicated, mask=all-ones for one cycle -> two cycles later wen=1, wb_vd=3, wb_data matches; one cycle after that wen=0.
- First contention: ALU vd=1 and SP vd=2 captured on the same edge -> wen cycle k writes vd=1, cycle k+1 writes vd=2; sp_ready=0 for exactly one cycle.
- ALU streaming vd=0..7 back-to-back, SP idle -> alu_ready constantly 1; eight consecutive wen pulses in order 0..7.
- Both streaming continuously with different vd -> writes alternate ALU, SP, ALU, SP; with VWB_PERF_CNT_EN, conflict_cnt counts every cycle both are held.
- Same vd ordering: SP vd=5 captured at edge N with a pending ALU entry, then ALU vd=5 captured at N+1 while last_grant=ALU -> the SP vd=5 write occurs before the ALU vd=5 write.
- Reset mid-operation: assert nRST low while both holding registers are full -> wen=0 and busy=0 immediately, with no write after release; the next ALU request wins the first contention.

Source files
------------

// File: rtl/vector_pkg.sv
// vector_pkg: shared vector types, including the write-back request and source enums.
package vector_pkg;
  localparam int NUM_ELEMENTS = 4;
  localparam int ELEM_W = 32;
  typedef logic [NUM_ELEMENTS-1:0][ELEM_W-1:0] vreg_t;
  typedef logic [4:0] vsel_t;
  typedef enum logic {WB_ALU, WB_SP} wb_src_t;
  typedef struct packed {
    vsel_t vd;
    vreg_t data;
    logic [NUM_ELEMENTS-1:0] mask;
  } wb_req_t;
endpackage

// File: rtl/vector_wb_hold.sv
// vector_wb_hold: one-entry holding register with a valid/ready handshake and grant release.
module vector_wb_hold
  import vector_pkg::*;
(
  input  logic    CLK,
  input  logic    nRST,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output logic    valid,
  output wb_req_t req
);
  assign ready = !valid || grant;
  // a capture on the grant edge overwrites the released entry, so no bubble
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      valid <= 1'b0;
      req <= '0;
    end else if (in_valid && ready) begin
      valid <= 1'b1;
      req <= in_req;
    end else if (grant) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/vector_wb_arbiter.sv
// vector_wb_arbiter: round-robin write-back arbiter for ALU and scratchpad results.
// Define VWB_PERF_CNT_EN to add the saturating conflict_cnt port.
module vector_wb_arbiter
  import vector_pkg::*;
#(
  parameter int NUM_ELEMENTS = vector_pkg::NUM_ELEMENTS,
  parameter int VD_W = $bits(vsel_t)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [VD_W-1:0]         alu_vd,
  input  vreg_t                   alu_data,
  input  logic [NUM_ELEMENTS-1:0] alu_mask,
  input  logic                    sp_valid,
  output logic                    sp_ready,
  input  logic [VD_W-1:0]         sp_vd,
  input  vreg_t                   sp_data,
  input  logic [NUM_ELEMENTS-1:0] sp_mask,
  output logic                    wen,
  output logic [VD_W-1:0]         wb_vd,
  output vreg_t                   wb_data,
  output logic [NUM_ELEMENTS-1:0] wb_mask,
  output logic                    busy
`ifdef VWB_PERF_CNT_EN
  ,output logic [31:0]            conflict_cnt
`endif
);
  wb_req_t alu_req, sp_req, wb_q;
  logic alu_hv, sp_hv, grant_alu, grant_sp, sp_older;
  wb_src_t last_grant;
  vector_wb_hold u_alu_hold (
    .CLK(CLK), .nRST(nRST), .in_valid(alu_valid),
    .in_req('{vd: alu_vd, data: alu_data, mask: alu_mask}),
    .grant(grant_alu), .ready(alu_ready), .valid(alu_hv), .req(alu_req)
  );
  vector_wb_hold u_sp_hold (
    .CLK(CLK), .nRST(nRST), .in_valid(sp_valid),
    .in_req('{vd: sp_vd, data: sp_data, mask: sp_mask}),
    .grant(grant_sp), .ready(sp_ready), .valid(sp_hv), .req(sp_req)
  );
  // equal destinations must retire oldest-first; a same-edge tie goes to ALU
  assign grant_alu = alu_hv && (!sp_hv || (alu_req.vd == sp_req.vd ? !sp_older : last_grant == WB_SP));
  assign grant_sp = sp_hv && !grant_alu;
  assign busy = alu_hv || sp_hv;
  assign wb_vd = wb_q.vd;
  assign wb_data = wb_q.data;
  assign wb_mask = wb_q.mask;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wen <= 1'b0;
      wb_q <= '0;
      last_grant <= WB_SP;
      sp_older <= 1'b0;
    end else begin
      wen <= grant_alu || grant_sp;
      if (grant_alu || grant_sp) begin
        wb_q <= grant_alu ? alu_req : sp_req;
        last_grant <= grant_alu ? WB_ALU : WB_SP;
      end
      sp_older <= (sp_valid && sp_ready) ? 1'b0 : (alu_valid && alu_ready) ? (sp_hv && !grant_sp) : sp_older;
    end
`ifdef VWB_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) conflict_cnt <= '0;
    else if (alu_hv && sp_hv && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_vector_wb_arbiter.sv
// tb_vector_wb_arbiter: scoreboard bench with directed write-back ordering vectors.
module tb_vector_wb_arbiter;
  import vector_pkg::*;
  logic CLK = 1'b0, nRST = 1'b0;
  logic alu_valid, alu_ready, sp_valid, sp_ready, wen, busy;
  vsel_t alu_vd, sp_vd, wb_vd;
  vreg_t alu_data, sp_data, wb_data;
  logic [NUM_ELEMENTS-1:0] alu_mask, sp_mask, wb_mask;
`ifdef VWB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif
  wb_req_t exp_q[$];
  int checks = 0, errors = 0;

  vector_wb_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vd(alu_vd), .alu_data(alu_data), .alu_mask(alu_mask),
    .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_vd(sp_vd), .sp_data(sp_data), .sp_mask(sp_mask),
    .wen(wen), .wb_vd(wb_vd), .wb_data(wb_data), .wb_mask(wb_mask), .busy(busy)
`ifdef VWB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic wb_req_t mk(input vsel_t vd, input logic [31:0] w, input logic [NUM_ELEMENTS-1:0] m);
    wb_req_t r;
    r.vd = vd;
    r.data = {NUM_ELEMENTS{w}};
    r.mask = m;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_alu(input logic v, input vsel_t vd, input logic [31:0] w, input logic [NUM_ELEMENTS-1:0] m);
    alu_valid = v; alu_vd = vd; alu_data = {NUM_ELEMENTS{w}}; alu_mask = m;
  endtask

  task automatic set_sp(input logic v, input vsel_t vd, input logic [31:0] w, input logic [NUM_ELEMENTS-1:0] m);
    sp_valid = v; sp_vd = vd; sp_data = {NUM_ELEMENTS{w}}; sp_mask = m;
  endtask

  task automatic idle();
    set_alu(0, 0, 0, 0);
    set_sp(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    repeat (2) step();
    nRST = 1'b1;
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge CLK) begin : monitor
    wb_req_t e;
    if (nRST && wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual vd=%0d data=%0h mask=%0h expected no write", wb_vd, wb_data, wb_mask);
      end else begin
        e = exp_q.pop_front();
        if (wb_vd !== e.vd || wb_data !== e.data || wb_mask !== e.mask) begin
          errors++;
          $display("FAIL wb_write actual vd=%0d data=%0h mask=%0h expected vd=%0d data=%0h mask=%0h",
                   wb_vd, wb_data, wb_mask, e.vd, e.data, e.mask);
        end
      end
    end
  end

  initial begin
    int ai, si;
    logic aa, ss;
    idle();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    chk("rst_wen", wen, 0);
    chk("rst_wb_vd", wb_vd, 0);
    chk("rst_wb_data", {31'd0, |wb_data}, 0);
    chk("rst_wb_mask", wb_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_sp_ready", sp_ready, 1);
    // ALU alone, latency
    set_alu(1, 3, 32'h1234, 4'hF);
    exp_q.push_back(mk(3, 32'h1234, 4'hF));
    step();
    idle();
    chk("lat_wen_n1", wen, 0);
    chk("lat_busy_n1", busy, 1);
    step();
    chk("lat_wen_n2", wen, 1);
    chk("lat_vd_n2", wb_vd, 3);
    chk("lat_busy_n2", busy, 0);
    step();
    chk("lat_wen_n3", wen, 0);
    // all-zero mask is still written
    set_alu(1, 4, 32'hDEAD, 4'h0);
    exp_q.push_back(mk(4, 32'hDEAD, 4'h0));
    step();
    idle();
    repeat (3) step();
    // first contention after reset: ALU wins
    do_reset();
    set_alu(1, 1, 32'hA1, 4'hF);
    set_sp(1, 2, 32'hB2, 4'hF);
    exp_q.push_back(mk(1, 32'hA1, 4'hF));
    exp_q.push_back(mk(2, 32'hB2, 4'hF));
    step();
    idle();
    chk("cont_alu_ready", alu_ready, 1);
    chk("cont_sp_ready_lose", sp_ready, 0);
    step();
    chk("cont_sp_ready_back", sp_ready, 1);
    repeat (3) step();
    // ALU streaming
    for (int i = 0; i < 8; i++) begin
      set_alu(1, vsel_t'(i), 32'h100 + i, 4'hF);
      exp_q.push_back(mk(vsel_t'(i), 32'h100 + i, 4'hF));
      chk("stream_alu_ready", alu_ready, 1);
      step();
    end
    idle();
    repeat (3) step();
    // both streaming: strict alternation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(vsel_t'(i), 32'h200 + i, 4'hF));
      exp_q.push_back(mk(vsel_t'(16 + i), 32'h300 + i, 4'h3));
    end
    ai = 0;
    si = 0;
    for (int c = 0; c < 12; c++) begin
      set_alu(ai < 4, vsel_t'(ai), 32'h200 + ai, 4'hF);
      set_sp(si < 4, vsel_t'(16 + si), 32'h300 + si, 4'h3);
      aa = alu_valid && alu_ready;
      ss = sp_valid && sp_ready;
      step();
      if (aa) ai++;
      if (ss) si++;
    end
    idle();
    chk("both_alu_count", ai, 4);
    chk("both_sp_count", si, 4);
`ifdef VWB_PERF_CNT_EN
    chk("conflict_cnt", conflict_cnt, 7);
`endif
    repeat (2) step();
    // same-vd ordering: older SP vd=5 retires before younger ALU vd=5
    set_alu(1, 30, 32'h5001, 4'hF);
    exp_q.push_back(mk(30, 32'h5001, 4'hF));
    step();
    idle();
    step();
    set_alu(1, 2, 32'h5002, 4'hF);
    set_sp(1, 9, 32'h5009, 4'hF);
    exp_q.push_back(mk(9, 32'h5009, 4'hF));
    exp_q.push_back(mk(2, 32'h5002, 4'hF));
    exp_q.push_back(mk(5, 32'h5005, 4'hF));
    exp_q.push_back(mk(5, 32'h6005, 4'hF));
    step();
    set_alu(0, 0, 0, 0);
    set_sp(1, 5, 32'h5005, 4'hF);
    chk("order_sp_ready", sp_ready, 1);
    chk("order_alu_ready", alu_ready, 0);
    step();
    set_sp(0, 0, 0, 0);
    set_alu(1, 5, 32'h6005, 4'hF);
    chk("order_alu_ready2", alu_ready, 1);
    step();
    idle();
    repeat (4) step();
    // same-edge tie on equal vd goes to ALU even though last grant was ALU
    set_alu(1, 12, 32'h7A, 4'hF);
    set_sp(1, 12, 32'h7B, 4'h1);
    exp_q.push_back(mk(12, 32'h7A, 4'hF));
    exp_q.push_back(mk(12, 32'h7B, 4'h1));
    step();
    idle();
    repeat (4) step();
    // reset mid-operation drops both held entries
    set_alu(1, 19, 32'h8C, 4'hF);
    exp_q.push_back(mk(19, 32'h8C, 4'hF));
    step();
    set_alu(1, 20, 32'h8A, 4'hF);
    set_sp(1, 21, 32'h8B, 4'hF);
    step();
    idle();
    chk("mid_busy_before", busy, 1);
    chk("mid_wen_before", wen, 1);
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("mid_wen_async", wen, 0);
    chk("mid_busy_async", busy, 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (3) step();
    set_alu(1, 1, 32'h9A, 4'hF);
    set_sp(1, 2, 32'h9B, 4'hF);
    exp_q.push_back(mk(1, 32'h9A, 4'hF));
    exp_q.push_back(mk(2, 32'h9B, 4'hF));
    step();
    idle();
    repeat (4) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
